// File: rtl/p_cache_pkg.sv
// Shared widths and FSM state encoding for the program cache.
package p_cache_pkg;

    localparam int unsigned ADDR_BITS     = 16;
    localparam int unsigned DATA_BITS     = 16;
    localparam int unsigned DEF_LINE_BITS = 6;
    localparam int unsigned DEF_OFFS_BITS = 3;

    typedef enum logic [2:0] {
        INV     = 3'd0,
        IDLE    = 3'd1,
        REQ     = 3'd2,
        FILL    = 3'd3,
        REFETCH = 3'd4
    } state_t;

endpackage

// File: rtl/p_cache_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module p_cache_ram #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset so the instruction output starts at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/p_cache.sv
// Direct-mapped instruction cache: one-cycle hit path, single-line refill from SDRAM bursts.
module p_cache
    import p_cache_pkg::*;
#(
    parameter int unsigned LINE_BITS = DEF_LINE_BITS,
    parameter int unsigned OFFS_BITS = DEF_OFFS_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] A,
    input  logic                 flush,
    output logic [DATA_BITS-1:0] I,
    output logic                 p_cache_miss,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic                 mem_valid,
    input  logic [DATA_BITS-1:0] mem_data
);

    localparam int unsigned TAG_BITS  = ADDR_BITS - LINE_BITS - OFFS_BITS;
    localparam int unsigned DADR_BITS = LINE_BITS + OFFS_BITS;

    state_t                 state;
    state_t                 state_nx;
    logic [ADDR_BITS-1:0]   a_q;
    logic [ADDR_BITS-1:0]   miss_addr;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic [OFFS_BITS-1:0]   beat;
    logic [LINE_BITS-1:0]   inv_idx;
    logic                   flush_pend;
    logic                   chk_q;
    logic                   hit;
    logic                   last_beat;

    logic                   tag_we;
    logic [LINE_BITS-1:0]   tag_waddr;
    logic [TAG_BITS:0]      tag_wdata;
    logic [TAG_BITS:0]      tag_rdata;
    logic                   data_we;
    logic [DADR_BITS-1:0]   data_waddr;
    logic [DATA_BITS-1:0]   data_rdata;

    // chk_q marks a RAM read that belongs to a fetch the PC is waiting on.
    assign hit       = chk_q && tag_rdata[TAG_BITS]
                       && (tag_rdata[TAG_BITS-1:0] == a_q[ADDR_BITS-1 -: TAG_BITS]);
    assign last_beat = (state == FILL) && mem_valid && (&beat);
    assign I         = data_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INV;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            INV:     if (!flush && (&inv_idx)) state_nx = IDLE;
            IDLE: begin
                if (flush)           state_nx = INV;
                else if (chk_q && !hit) state_nx = REQ;
            end
            REQ:     if (mem_ack) state_nx = FILL;
            FILL:    if (last_beat) state_nx = (flush || flush_pend) ? INV : REFETCH;
            REFETCH: state_nx = (flush || flush_pend) ? INV : IDLE;
            default: state_nx = INV;
        endcase
    end

    always_comb begin
        rd_addr      = A;
        tag_we       = 1'b0;
        tag_waddr    = inv_idx;
        tag_wdata    = '0;
        data_we      = 1'b0;
        data_waddr   = {miss_addr[DADR_BITS-1:OFFS_BITS], beat};
        p_cache_miss = !hit;
        case (state)
            INV:     tag_we = 1'b1;
            FILL: begin
                data_we = mem_valid;
                if (last_beat) begin
                    tag_we    = 1'b1;
                    tag_waddr = miss_addr[DADR_BITS-1:OFFS_BITS];
                    tag_wdata = {1'b1, miss_addr[ADDR_BITS-1 -: TAG_BITS]};
                end
            end
            REFETCH: rd_addr = miss_addr;
            default: ;
        endcase
    end

    // Address pipeline, miss capture, fill request, counters and deferred flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            miss_addr  <= '0;
            mem_addr   <= '0;
            mem_req    <= 1'b0;
            beat       <= '0;
            inv_idx    <= '0;
            flush_pend <= 1'b0;
            chk_q      <= 1'b0;
        end else begin
            a_q     <= rd_addr;
            chk_q   <= (state_nx == IDLE) && ((state == IDLE) || (state == REFETCH));
            mem_req <= (state_nx == REQ);
            if ((state == IDLE) && (state_nx == REQ)) begin
                miss_addr <= a_q;
                mem_addr  <= {a_q[ADDR_BITS-1:OFFS_BITS], {OFFS_BITS{1'b0}}};
            end
            if (state != FILL) begin
                beat <= '0;
            end else if (mem_valid) begin
                beat <= beat + OFFS_BITS'(1);
            end
            if ((state != INV) || flush) begin
                inv_idx <= '0;
            end else begin
                inv_idx <= inv_idx + LINE_BITS'(1);
            end
            if (state_nx == INV) begin
                flush_pend <= 1'b0;
            end else if (flush && (state != IDLE) && (state != INV)) begin
                flush_pend <= 1'b1;
            end
        end
    end

    p_cache_ram #(.AW(LINE_BITS), .DW(TAG_BITS + 1)) u_tag_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (tag_we),
        .waddr (tag_waddr),
        .wdata (tag_wdata),
        .raddr (rd_addr[DADR_BITS-1:OFFS_BITS]),
        .rdata (tag_rdata)
    );

    p_cache_ram #(.AW(DADR_BITS), .DW(DATA_BITS)) u_data_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (data_we),
        .waddr (data_waddr),
        .wdata (mem_data),
        .raddr (rd_addr[DADR_BITS-1:0]),
        .rdata (data_rdata)
    );

endmodule
